sensor_frame_ctrl: RTL and testbench
====================================

// Module: sensor_frame_ctrl
// PURPOSE
//  Frame sequencer for the sensor model: drives its 2-bit nstate (IDLE/VSYNC/HSYNC/DATA) so one frame
//  of HEIGHT lines x WIDTH/2 pixel-pair cycles is streamed. Sits beside the sensor on the HCLK domain.
//  Monitors the sensor's ctrl_done for sequencing agreement and reports frame/line progress.
// PARAMETERS
//  WIDTH      240  pixels per line; must be even (2 pixels per DATA cycle), <= 65534
//  HEIGHT     320  lines per frame, 1..65535
//  VSYNC_CYC  100  cycles nstate=VSYNC per frame, >= 1
//  HSYNC_CYC  160  cycles nstate=HSYNC before every line, >= 1
// PORTS
//  HCLK        in   1   clock, rising edge
//  HRESETn     in   1   asynchronous active-low reset
//  start       in   1   frame request; sampled only in S_IDLE
//  abort       in   1   synchronous abort; highest priority after reset
//  ctrl_done   in   1   sensor end-of-frame flag
//  nstate      out  2   sensor state: 00 IDLE, 01 VSYNC, 10 HSYNC, 11 DATA (registered)
//  busy        out  1   1 in any state except S_IDLE
//  frame_done  out  1   one-cycle pulse in S_DONE
//  line_cnt    out  16  current line index 0..HEIGHT-1
//  sync_err    out  1   sticky sequencing-mismatch flag
// BEHAVIOUR
//  - Reset (async, HRESETn=0): state=S_IDLE, nstate=00, busy=0, frame_done=0, line_cnt=0, sync_err=0,
//    internal cycle counter cyc=0. All outputs registered; nstate is a direct encoding of state.
//  - States -> nstate: S_IDLE 00, S_VSYNC 01, S_HSYNC 10, S_DATA 11, S_DONE 00.
//  - S_IDLE: start=1 -> S_VSYNC next edge, cyc=0, line_cnt=0. start=0 -> stay.
//  - S_VSYNC: held exactly VSYNC_CYC cycles (cyc counts 0..VSYNC_CYC-1), then S_HSYNC, cyc=0.
//  - S_HSYNC: held exactly HSYNC_CYC cycles, then S_DATA, cyc=0.
//  - S_DATA: held exactly WIDTH/2 cycles. At end: line_cnt<HEIGHT-1 -> line_cnt+1, S_HSYNC;
//    line_cnt==HEIGHT-1 -> S_DONE.
//  - S_DONE: exactly 1 cycle; frame_done=1; nstate=00 (clears sensor ctrl_done/counters); line_cnt
//    held at HEIGHT-1 during S_DONE, cleared to 0 on exit. Exit -> S_IDLE.
//  - Frame length start-sample to frame_done inclusive: VSYNC_CYC + HEIGHT*(HSYNC_CYC+WIDTH/2) + 1.
//  - start during busy: ignored (no queuing). start high in S_DONE's cycle is not sampled.
//  - abort=1 in any state: next edge -> S_IDLE, cyc=0, line_cnt=0, no frame_done pulse.
//    abort and start both high in S_IDLE: abort wins, stay S_IDLE.
//  - sync_err set (sticky until reset) when: ctrl_done=1 during S_VSYNC, S_HSYNC or S_DATA; or
//    ctrl_done=0 during S_DONE. Never cleared by abort or start.
//  - Counters 16-bit unsigned; compares against parameter-1 values; no wrap in legal configs.
//  - Reset asserted mid-frame: immediate return to reset values; next frame needs new start.
// CONFIGURATION
//  SENSOR_FRAME_CTRL_CONT_EN defined: continuous mode; S_DONE -> S_VSYNC (not S_IDLE) and frames
//    repeat back-to-back until abort; start only needed for the first frame; busy stays 1.
//  Not defined: single-shot; S_DONE -> S_IDLE, each frame needs a start pulse.
// TESTING  (WIDTH=8, HEIGHT=4, VSYNC_CYC=3, HSYNC_CYC=2 unless stated)
//  1 Reset then idle: HRESETn=0 -> nstate=00, busy=0, line_cnt=0, sync_err=0; stays so with start=0.
//  2 Single frame: 1-cycle start -> nstate 01x3, then 4x(10x2, 11x4), then 00 with frame_done=1;
//    frame_done 28 cycles after start sampled; with sensor model attached, sync_err=0, 32 pixels out.
//  3 Abort mid-line: abort during 2nd S_DATA cycle of line 2 -> next cycle nstate=00, line_cnt=0,
//    no frame_done; subsequent start produces a full 28-cycle frame.
//  4 Mismatch: force ctrl_done=1 during S_HSYNC -> sync_err=1 and stays 1 through next frame;
//    separately ctrl_done=0 in S_DONE -> sync_err=1.
//  5 Start while busy / abort+start: start pulses mid-frame ignored (frame_done once);
//    abort=start=1 in S_IDLE -> stays S_IDLE.
//  6 CONT_EN build: one start -> frame_done every 28 cycles, nstate 00 for exactly 1 cycle between
//    frames; abort -> S_IDLE, busy=0.

Source files
------------

// File: rtl/sensor_frame_ctrl_if.sv
// Control/status bundle between the frame sequencer and its host/sensor side.
// master = host/bench side, slave = sensor_frame_ctrl.
interface sensor_frame_ctrl_if;
   logic        start;
   logic        abort;
   logic        ctrl_done;
   logic [1:0]  nstate;
   logic        busy;
   logic        frame_done;
   logic [15:0] line_cnt;
   logic        sync_err;

   modport master (
      output start, abort, ctrl_done,
      input  nstate, busy, frame_done, line_cnt, sync_err
   );

   modport slave (
      input  start, abort, ctrl_done,
      output nstate, busy, frame_done, line_cnt, sync_err
   );
endinterface

// File: rtl/sensor_frame_ctrl.sv
// Frame sequencer driving the sensor nstate through VSYNC / HSYNC / DATA for one frame.
// Define SENSOR_FRAME_CTRL_CONT_EN for continuous back-to-back frames until abort.
module sensor_frame_ctrl #(
   parameter int WIDTH     = 240,
   parameter int HEIGHT    = 320,
   parameter int VSYNC_CYC = 100,
   parameter int HSYNC_CYC = 160
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   sensor_frame_ctrl_if.slave  bus,
   output logic [2:0]          dbg_state_o
);

   // Low two bits of each encoding are the sensor nstate, so nstate comes straight off the flops.
   typedef enum logic [2:0] {
      S_IDLE  = 3'b000,
      S_VSYNC = 3'b001,
      S_HSYNC = 3'b010,
      S_DATA  = 3'b011,
      S_DONE  = 3'b100
   } state_t;

   localparam logic [15:0] VS_LAST = 16'(VSYNC_CYC - 1);
   localparam logic [15:0] HS_LAST = 16'(HSYNC_CYC - 1);
   localparam logic [15:0] DA_LAST = 16'(WIDTH / 2 - 1);
   localparam logic [15:0] LN_LAST = 16'(HEIGHT - 1);

   state_t      state_q, state_d;
   logic [15:0] cyc_q, cyc_d;
   logic [15:0] line_q, line_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         line_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         line_q  <= line_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q + 16'd1;
      line_d  = line_q;
      err_d   = err_q;

      // Sensor must not flag end-of-frame mid-frame, and must flag it while we are in S_DONE.
      case (state_q)
         S_VSYNC, S_HSYNC, S_DATA: if (bus.ctrl_done)  err_d = 1'b1;
         S_DONE:                   if (!bus.ctrl_done) err_d = 1'b1;
         default: ;
      endcase

      if (bus.abort) begin
         state_d = S_IDLE;
         cyc_d   = '0;
         line_d  = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cyc_d = '0;
               if (bus.start) begin
                  state_d = S_VSYNC;
                  line_d  = '0;
               end
            end
            S_VSYNC: begin
               if (cyc_q == VS_LAST) begin
                  state_d = S_HSYNC;
                  cyc_d   = '0;
               end
            end
            S_HSYNC: begin
               if (cyc_q == HS_LAST) begin
                  state_d = S_DATA;
                  cyc_d   = '0;
               end
            end
            S_DATA: begin
               if (cyc_q == DA_LAST) begin
                  cyc_d = '0;
                  if (line_q == LN_LAST) begin
                     state_d = S_DONE;
                  end else begin
                     line_d  = line_q + 16'd1;
                     state_d = S_HSYNC;
                  end
               end
            end
            S_DONE: begin
               cyc_d  = '0;
               line_d = '0;
`ifdef SENSOR_FRAME_CTRL_CONT_EN
               state_d = S_VSYNC;
`else
               state_d = S_IDLE;
`endif
            end
            default: begin
               state_d = S_IDLE;
               cyc_d   = '0;
               line_d  = '0;
            end
         endcase
      end

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   assign bus.nstate     = state_q[1:0];
   assign bus.busy       = busy_q;
   assign bus.frame_done = done_q;
   assign bus.line_cnt   = line_q;
   assign bus.sync_err   = err_q;
   assign dbg_state_o    = state_q;

endmodule

// File: tb/tb_sensor_frame_ctrl.sv
// Bench for sensor_frame_ctrl with WIDTH=8, HEIGHT=4, VSYNC_CYC=3, HSYNC_CYC=2.
// Frame records are queued by the stimulus and popped by a frame_done monitor.
module tb_sensor_frame_ctrl;

   localparam int W = 32;

   logic HCLK    = 1'b0;
   logic HRESETn = 1'b0;
   logic [2:0] dbg_state;

   always #5 HCLK = ~HCLK;

   sensor_frame_ctrl_if bus ();

   sensor_frame_ctrl #(
      .WIDTH(8), .HEIGHT(4), .VSYNC_CYC(3), .HSYNC_CYC(2)
   ) dut (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .bus         (bus),
      .dbg_state_o (dbg_state)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc_n     = 0;
   int start_cyc = 0;
   int pix_cnt   = 0;
   int force_mode = 0;   // 0 sensor model, 1 force ctrl_done=1, 2 force ctrl_done=0

   logic [W-1:0] exp_q[$];
   logic [W-1:0] mon_got;
   logic [W-1:0] mon_exp;

   // Sensor model: counts DATA pixel pairs, raises ctrl_done after a full frame, clears on nstate=00.
   always @(posedge HCLK) begin
      cyc_n <= cyc_n + 1;
      if (bus.nstate == 2'b00)      pix_cnt <= 0;
      else if (bus.nstate == 2'b11) pix_cnt <= pix_cnt + 1;
   end

   assign bus.ctrl_done = (force_mode == 1) ? 1'b1 :
                          (force_mode == 2) ? 1'b0 : (pix_cnt == 16);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Frame record: {latency, pixels, line_cnt, sync_err}; latency counts first VSYNC cycle through S_DONE.
   function automatic logic [W-1:0] fr(input int lat, input int pix, input int line, input bit err);
      return {8'(lat), 8'(pix), 15'(line), err};
   endfunction

   always @(negedge HCLK) begin
      if (HRESETn && bus.frame_done) begin
         mon_got = {8'(cyc_n - start_cyc + 1), 8'(2 * pix_cnt), 15'(bus.line_cnt), bus.sync_err};
         if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_frame_done: got %0h expected no frame (t=%0t)", mon_got, $time);
         end else begin
            mon_exp = exp_q.pop_front();
            check("frame_record", mon_got, mon_exp);
         end
         start_cyc = cyc_n + 1;
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge HCLK);
   endtask

   // Returns on the first VSYNC cycle (cycle 1 of the frame).
   task automatic start_pulse();
      @(negedge HCLK);
      bus.start = 1'b1;
      @(negedge HCLK);
      bus.start = 1'b0;
      start_cyc = cyc_n;
   endtask

   task automatic wait_frames();
      int budget;
      budget = 300;
      while (exp_q.size() != 0 && budget > 0) begin
         @(negedge HCLK);
         #1;
         budget--;
      end
      if (exp_q.size() != 0) begin
         total_cnt++;
         $display("FAIL frame_timeout: got %0d pending frames expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Expected {busy, nstate, line_cnt[7:0]} in cycle k (1..28) of a frame.
   function automatic logic [31:0] exp_cyc(input int k);
      int m;
      if (k <= 3) return {21'd0, 1'b1, 2'b01, 8'd0};
      if (k == 28) return {21'd0, 1'b1, 2'b00, 8'd3};
      m = k - 4;
      return {21'd0, 1'b1, ((m % 6) < 2) ? 2'b10 : 2'b11, 8'(m / 6)};
   endfunction

   function automatic logic [31:0] act_cyc();
      return {21'd0, bus.busy, bus.nstate, bus.line_cnt[7:0]};
   endfunction

   task automatic check_idle(input string name);
      check(name, {29'd0, bus.busy, bus.nstate}, 32'd0);
      check({name, "_line"}, {16'd0, bus.line_cnt}, 32'd0);
   endtask

   initial begin
      bus.start = 1'b0;
      bus.abort = 1'b0;

      // Reset and idle
      #2;
      check_idle("reset_idle");
      check("reset_sync_err", {31'd0, bus.sync_err}, 32'd0);
      check("reset_frame_done", {31'd0, bus.frame_done}, 32'd0);
      step(1);
      HRESETn = 1'b1;
      step(5);
      check_idle("idle_no_start");

`ifdef SENSOR_FRAME_CTRL_CONT_EN
      exp_q.push_back(fr(28, 32, 3, 0));
      exp_q.push_back(fr(28, 32, 3, 0));
      exp_q.push_back(fr(28, 32, 3, 0));
      start_pulse();
      for (int k = 1; k <= 84; k++) begin
         if (k > 1) @(negedge HCLK);
         check("cont_seq", act_cyc(), exp_cyc((k - 1) % 28 + 1));
      end
      #1;
      check("cont_frames_seen", exp_q.size(), 32'd0);
      @(negedge HCLK);
      bus.abort = 1'b1;
      @(negedge HCLK);
      bus.abort = 1'b0;
      check_idle("cont_abort");
      step(40);
      check_idle("cont_stays_idle");
`else
      // Single frame with full nstate sequence
      exp_q.push_back(fr(28, 32, 3, 0));
      start_pulse();
      for (int k = 1; k <= 28; k++) begin
         if (k > 1) @(negedge HCLK);
         check("frame_seq", act_cyc(), exp_cyc(k));
      end
      @(negedge HCLK);
      check_idle("after_frame");
      wait_frames();

      // Abort in the 2nd DATA cycle of line 2 (frame cycle 19)
      start_pulse();
      step(18);
      check("abort_point", act_cyc(), {21'd0, 1'b1, 2'b11, 8'd2});
      bus.abort = 1'b1;
      @(negedge HCLK);
      bus.abort = 1'b0;
      check_idle("after_abort");
      step(35);
      check_idle("abort_no_restart");
      exp_q.push_back(fr(28, 32, 3, 0));
      start_pulse();
      wait_frames();

      // start pulses while busy, and start high during S_DONE
      exp_q.push_back(fr(28, 32, 3, 0));
      start_pulse();
      step(4);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      step(14);
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      step(7);
      check("done_cycle", act_cyc(), exp_cyc(28));
      bus.start = 1'b1;
      step(1);
      bus.start = 1'b0;
      check_idle("done_start_ignored");
      step(35);
      check_idle("no_second_frame");
      #1;
      check("busy_frames_seen", exp_q.size(), 32'd0);

      // abort and start together in S_IDLE
      @(negedge HCLK);
      bus.abort = 1'b1;
      bus.start = 1'b1;
      @(negedge HCLK);
      bus.abort = 1'b0;
      bus.start = 1'b0;
      check_idle("abort_start_idle");
      check("abort_start_dbg", {29'd0, dbg_state}, 32'd0);

      // Reset mid-frame
      start_pulse();
      step(9);
      HRESETn = 1'b0;
      #1;
      check_idle("reset_mid_frame");
      check("reset_mid_frame_err", {31'd0, bus.sync_err}, 32'd0);
      @(negedge HCLK);
      HRESETn = 1'b1;
      step(40);
      check_idle("reset_no_restart");

      // ctrl_done=0 while in S_DONE
      force_mode = 2;
      exp_q.push_back(fr(28, 32, 3, 0));
      start_pulse();
      wait_frames();
      @(negedge HCLK);
      check("done_low_err", {31'd0, bus.sync_err}, 32'd1);
      force_mode = 0;

      // ctrl_done=1 during S_HSYNC; sticky through the next frame
      HRESETn = 1'b0;
      step(1);
      HRESETn = 1'b1;
      check("err_cleared_by_reset", {31'd0, bus.sync_err}, 32'd0);
      exp_q.push_back(fr(28, 32, 3, 1));
      start_pulse();
      step(3);
      check("hsync_point", {30'd0, bus.nstate}, 32'd2);
      force_mode = 1;
      step(1);
      force_mode = 0;
      check("hsync_err", {31'd0, bus.sync_err}, 32'd1);
      wait_frames();
      exp_q.push_back(fr(28, 32, 3, 1));
      start_pulse();
      wait_frames();
      @(negedge HCLK);
      check("err_sticky", {31'd0, bus.sync_err}, 32'd1);
`endif

      step(2);
      #1;
      check("queue_drained", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
